// File: rtl/prog_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_loader_if
//  Description : Bundle between the instruction memory/loader and its users.
//                The bundle carries two groups of signals:
//                  - the CPU fetch path (iAddress -> oInstruction/oInstrValid)
//                  - the byte-serial load port (iLoadStart/iLoadLength,
//                    iByteValid/iByte -> oByteReady/oLoadBusy/oLoadDone)
//                The slave modport is taken by the memory. The master
//                modport is taken by whoever drives fetch and load traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_mem_loader_if #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] iAddress;
    logic [DATA_WIDTH-1:0] oInstruction;
    logic                  oInstrValid;
    logic                  iLoadStart;
    logic [ADDR_WIDTH:0]   iLoadLength;
    logic                  iByteValid;
    logic [7:0]            iByte;
    logic                  oByteReady;
    logic                  oLoadBusy;
    logic                  oLoadDone;

    modport slave (
        input  iAddress, iLoadStart, iLoadLength, iByteValid, iByte,
        output oInstruction, oInstrValid, oByteReady, oLoadBusy, oLoadDone
    );

    modport master (
        output iAddress, iLoadStart, iLoadLength, iByteValid, iByte,
        input  oInstruction, oInstrValid, oByteReady, oLoadBusy, oLoadDone
    );
endinterface
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_mem_loader
//  Description : Synchronously read instruction memory whose contents can be
//                reloaded at run time through a byte-serial port. Bytes are
//                sent MSB-first, and each word takes BYTES_PER_WORD bytes.
//                The CPU is held off with oInstrValid while a load runs.
//  Ports       : Clock - system clock, rising edge
//                Reset - synchronous, active-high
//                bus   - prog_mem_loader_if.slave, which carries both the
//                        fetch path and the load port
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_loader #(
    parameter int                    DATA_WIDTH = 28,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    prog_mem_loader_if.slave bus
);

    localparam int BYTES_PER_WORD = (DATA_WIDTH + 7) / 8;
    localparam int DEPTH          = 1 << ADDR_WIDTH;
    localparam int c_BCNT_W       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE  = c_BCNT_W'(1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_WPTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   w_wptr_inc;
    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic [c_BCNT_W-1:0]   r_bcnt;
    logic [DATA_WIDTH-1:0] w_asm_next;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  w_start;
    logic                  w_byte_acc;
    logic                  w_word_done;
    logic                  w_byte_ready;
    logic                  w_load_busy;
    logic                  w_load_done;

    // The array is never reset. The initialiser below is its configuration
    // content, and keeping the array free of resets lets it map onto block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: FILL_WORD};

    // A request longer than the memory is clamped, so the write pointer can
    // never wrap back onto word 0.
    assign w_len_clamped = (bus.iLoadLength > c_DEPTH) ? c_DEPTH : bus.iLoadLength;
    assign w_wptr_inc    = r_wptr + c_WPTR_ONE;

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_byte_acc   = 1'b0;
        w_word_done  = 1'b0;
        w_byte_ready = 1'b0;
        w_load_busy  = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.iLoadStart) begin
                    w_start      = 1'b1;
                    w_state_next = (w_len_clamped == '0) ? c_ST_FINISH : c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_load_busy  = 1'b1;
                w_byte_ready = 1'b1;
                w_byte_acc   = bus.iByteValid;
                w_word_done  = bus.iByteValid && (r_bcnt == c_BCNT_LAST);
                if (w_word_done && (w_wptr_inc == r_len))
                    w_state_next = c_ST_FINISH;
            end
            c_ST_FINISH: begin
                w_load_done  = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_len  <= '0;
            r_wptr <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_start) begin
                r_len  <= w_len_clamped;
                r_wptr <= '0;
                r_bcnt <= '0;
            end
            if (w_byte_acc) begin
                if (w_word_done) begin
                    r_bcnt <= '0;
                    r_wptr <= w_wptr_inc;
                end else begin
                    r_bcnt <= r_bcnt + c_BCNT_ONE;
                end
            end
        end
    end

    // The assembly register only keeps the bits that can still reach the
    // word. Excess high bits of the first byte are shifted out and lost.
    generate
        if (DATA_WIDTH > 8) begin : g_asm_shift
            logic [DATA_WIDTH-9:0] r_asm;
            assign w_asm_next = {r_asm, bus.iByte};
            always_ff @(posedge Clock) begin
                if (Reset)           r_asm <= '0;
                else if (w_byte_acc) r_asm <= w_asm_next[DATA_WIDTH-9:0];
            end
        end else begin : g_asm_single
            assign w_asm_next = bus.iByte[DATA_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (w_word_done && !Reset)
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= w_asm_next;
    end

    // Fetch runs only in IDLE, so a read never collides with a load write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_instr       <= FILL_WORD;
            r_instr_valid <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            r_instr       <= r_mem[bus.iAddress];
            r_instr_valid <= 1'b1;
        end else begin
            r_instr       <= FILL_WORD;
            r_instr_valid <= 1'b0;
        end
    end

    assign bus.oInstruction = r_instr;
    assign bus.oInstrValid  = r_instr_valid;
    assign bus.oByteReady   = w_byte_ready;
    assign bus.oLoadBusy    = w_load_busy;
    assign bus.oLoadDone    = w_load_done;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_mem_loader
//  Description : Directed self-checking bench for prog_mem_loader. The main
//                instance uses the default geometry. A second instance with
//                ADDR_WIDTH = 2 covers length clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_loader;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    int   done_base;
    logic [7:0] stim [0:31];

    always #5 Clock = ~Clock;

    prog_mem_loader_if #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) bus ();
    prog_mem_loader_if #(.DATA_WIDTH(28), .ADDR_WIDTH(2)) bus2 ();

    prog_mem_loader #(.DATA_WIDTH(28), .ADDR_WIDTH(8), .FILL_WORD(28'h0)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    prog_mem_loader #(.DATA_WIDTH(28), .ADDR_WIDTH(2), .FILL_WORD(28'h0)) dut2 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus2)
    );

    always @(negedge Clock) if (bus.oLoadDone === 1'b1) done_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [8:0] len);
        bus.iLoadLength = len;
        bus.iLoadStart  = 1'b1;
        step();
        bus.iLoadStart  = 1'b0;
    endtask

    // Sends stim[0..n-1] on the main port. A second start is pulsed together
    // with byte start_at (-1 means none), and gap idle cycles separate the bytes.
    task automatic feed(input int n, input int gap, input int start_at);
        for (int i = 0; i < n; i++) begin
            bus.iByteValid = 1'b1;
            bus.iByte      = stim[i];
            if (i == start_at) begin
                bus.iLoadStart  = 1'b1;
                bus.iLoadLength = 9'd1;
            end
            step();
            bus.iByteValid = 1'b0;
            bus.iLoadStart = 1'b0;
            check("valid_low_in_load", {31'b0, bus.oInstrValid}, 32'd0);
            if (i != n - 1)
                for (int g = 0; g < gap; g++) begin
                    step();
                    check("valid_low_in_gap", {31'b0, bus.oInstrValid}, 32'd0);
                end
        end
    endtask

    // Shared tail of a two-word load of ABCDEF1 / 1234567 that ends at edge M.
    task automatic finish_two_words();
        check("done_at_last_byte", {31'b0, bus.oLoadDone}, 32'd1);
        check("ready_low_finish",  {31'b0, bus.oByteReady}, 32'd0);
        bus.iAddress = 8'd0;
        step();
        check("done_one_cycle", {31'b0, bus.oLoadDone}, 32'd0);
        check("valid_low_finish", {31'b0, bus.oInstrValid}, 32'd0);
        step();
        check("fetch0_valid", {31'b0, bus.oInstrValid}, 32'd1);
        check("fetch0_word", 32'(bus.oInstruction), 32'h0ABCDEF1);
        bus.iAddress = 8'd1;
        step();
        check("fetch1_word", 32'(bus.oInstruction), 32'h01234567);
    endtask

    initial begin
        bus.iAddress = '0;  bus.iLoadStart = 1'b0; bus.iLoadLength = '0;
        bus.iByteValid = 1'b0; bus.iByte = '0;
        bus2.iAddress = '0; bus2.iLoadStart = 1'b0; bus2.iLoadLength = '0;
        bus2.iByteValid = 1'b0; bus2.iByte = '0;

        // Reset, then fetch from the configuration contents.
        step();
        step();
        check("rst_instr", 32'(bus.oInstruction), 32'h0);
        check("rst_valid", {31'b0, bus.oInstrValid}, 32'd0);
        check("rst_ready", {31'b0, bus.oByteReady}, 32'd0);
        check("rst_busy",  {31'b0, bus.oLoadBusy}, 32'd0);
        check("rst_done",  {31'b0, bus.oLoadDone}, 32'd0);
        Reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus.iAddress = 8'(a);
            step();
            check("fill_valid", {31'b0, bus.oInstrValid}, 32'd1);
            check("fill_word", 32'(bus.oInstruction), 32'h0);
        end

        stim[0] = 8'h0A; stim[1] = 8'hBC; stim[2] = 8'hDE; stim[3] = 8'hF1;
        stim[4] = 8'h01; stim[5] = 8'h23; stim[6] = 8'h45; stim[7] = 8'h67;

        // Gapped load with a second start pulse in the middle of the load.
        done_base = done_cnt;
        start_load(9'd2);
        check("busy_after_start",  {31'b0, bus.oLoadBusy}, 32'd1);
        check("ready_after_start", {31'b0, bus.oByteReady}, 32'd1);
        check("valid_kept_start",  {31'b0, bus.oInstrValid}, 32'd1);
        feed(8, 3, 3);
        finish_two_words();
        check("gapped_done_count", 32'(done_cnt - done_base), 32'd1);

        // Basic back-to-back load of the same data.
        done_base = done_cnt;
        start_load(9'd2);
        feed(8, 0, -1);
        finish_two_words();
        check("basic_done_count", 32'(done_cnt - done_base), 32'd1);

        // A zero-length load finishes at once and writes nothing.
        bus.iAddress = 8'd0;
        start_load(9'd0);
        check("zero_done", {31'b0, bus.oLoadDone}, 32'd1);
        check("zero_busy", {31'b0, bus.oLoadBusy}, 32'd0);
        check("zero_ready", {31'b0, bus.oByteReady}, 32'd0);
        step();
        check("zero_done_drop", {31'b0, bus.oLoadDone}, 32'd0);
        check("zero_valid_low", {31'b0, bus.oInstrValid}, 32'd0);
        step();
        check("zero_valid_back", {31'b0, bus.oInstrValid}, 32'd1);
        check("zero_no_write", 32'(bus.oInstruction), 32'h0ABCDEF1);

        // Reset after one full word and half of the next word.
        stim[0] = 8'h01; stim[1] = 8'h11; stim[2] = 8'h11; stim[3] = 8'h11;
        stim[4] = 8'h02; stim[5] = 8'h22;
        done_base = done_cnt;
        start_load(9'd3);
        feed(6, 0, -1);
        Reset = 1'b1;
        step();
        check("midrst_busy",  {31'b0, bus.oLoadBusy}, 32'd0);
        check("midrst_ready", {31'b0, bus.oByteReady}, 32'd0);
        check("midrst_valid", {31'b0, bus.oInstrValid}, 32'd0);
        Reset = 1'b0;
        bus.iAddress = 8'd0;
        step();
        check("midrst_idle_fetch", {31'b0, bus.oInstrValid}, 32'd1);
        check("midrst_word0_new", 32'(bus.oInstruction), 32'h01111111);
        bus.iAddress = 8'd1;
        step();
        check("midrst_word1_old", 32'(bus.oInstruction), 32'h01234567);
        bus.iAddress = 8'd2;
        step();
        check("midrst_word2_old", 32'(bus.oInstruction), 32'h0);
        check("midrst_no_done", 32'(done_cnt - done_base), 32'd0);

        // Overlength on the 4-word instance: 7 words requested, 4 written.
        bus2.iLoadLength = 3'd7;
        bus2.iLoadStart  = 1'b1;
        step();
        bus2.iLoadStart  = 1'b0;
        for (int k = 0; k < 28; k++) begin
            if (k < 16) check("ovl_ready_high", {31'b0, bus2.oByteReady}, 32'd1);
            bus2.iByteValid = 1'b1;
            bus2.iByte      = 8'(k + 1);
            step();
            if (k == 15) begin
                check("ovl_done", {31'b0, bus2.oLoadDone}, 32'd1);
                check("ovl_ready_drop", {31'b0, bus2.oByteReady}, 32'd0);
            end else if (k > 15) begin
                check("ovl_ready_low", {31'b0, bus2.oByteReady}, 32'd0);
                check("ovl_no_done", {31'b0, bus2.oLoadDone}, 32'd0);
            end
        end
        bus2.iByteValid = 1'b0;
        bus2.iAddress = 2'd0; step();
        check("ovl_word0", 32'(bus2.oInstruction), 32'h01020304);
        bus2.iAddress = 2'd1; step();
        check("ovl_word1", 32'(bus2.oInstruction), 32'h05060708);
        bus2.iAddress = 2'd2; step();
        check("ovl_word2", 32'(bus2.oInstruction), 32'h090A0B0C);
        bus2.iAddress = 2'd3; step();
        check("ovl_word3", 32'(bus2.oInstruction), 32'h0D0E0F10);
        check("ovl_valid", {31'b0, bus2.oInstrValid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_mem_loader.md
# prog_mem_loader

- Parametrised, synchronously read instruction memory for the soft CPU.
- Replaces the fixed combinational program table.
- Contents can be rewritten at run time through a byte-serial load port, fed e.g. from the UART receiver, so new programs run without resynthesis.
- Sits between the CPU fetch stage and the host link. While a load is in progress it holds the CPU off via an instruction-valid flag.

## Interface
Parameters:
- DATA_WIDTH, 28, instruction word width (1..32)
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words
- FILL_WORD, 28'h0, power-up content of every word and output value while invalid
- Derived localparam BYTES_PER_WORD = ceil(DATA_WIDTH/8) (4 at default)

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- iAddress  in  ADDR_WIDTH  fetch address
- oInstruction  out  DATA_WIDTH  registered instruction read from iAddress
- oInstrValid  out  1  oInstruction is a valid fetch result
- iLoadStart  in  1  one-cycle pulse, begins a program load at address 0
- iLoadLength  in  ADDR_WIDTH+1  number of words to load, sampled with iLoadStart
- iByteValid  in  1  iByte carries a load byte this cycle
- iByte  in  8  load data, most-significant byte of each word first
- oByteReady  out  1  loader accepts a byte this cycle
- oLoadBusy  out  1  load in progress
- oLoadDone  out  1  one-cycle pulse, last word written

## Operation
- The memory array is not cleared by Reset. It is initialised to FILL_WORD at configuration only, which keeps it BRAM-inferable. Words written by a load persist across Reset.
- The FSM has three states: IDLE, LOAD, FINISH.
- IDLE:
  - fetch active; oInstruction <= mem[iAddress] each cycle; oInstrValid <= 1.
  - iLoadStart = 1: latch len = min(iLoadLength, DEPTH); clear the write pointer wptr and byte counter bcnt.
  - If len = 0, go to FINISH; otherwise go to LOAD.
- LOAD:
  - oLoadBusy = 1; oByteReady = 1; oInstrValid <= 0; oInstruction <= FILL_WORD.
  - Byte accept: iByteValid = 1 shifts iByte into the assembly register: asm <= {asm, iByte}; bcnt increments.
  - On the byte that makes bcnt = BYTES_PER_WORD: write mem[wptr] <= low DATA_WIDTH bits of the assembled word; excess high bits of the first byte are discarded; bcnt <= 0; wptr increments.
  - When the word written is word number len, go to FINISH.
  - iLoadStart while in LOAD is ignored.
- FINISH:
  - Lasts exactly 1 cycle; oLoadDone = 1; oByteReady = 0; oInstrValid <= 0.
  - Next state is IDLE.
- wptr is ADDR_WIDTH+1 bits wide. Because len is clamped to DEPTH, writes never wrap. Bytes arriving after the final word are not accepted (oByteReady = 0).
- iByteValid outside LOAD is ignored.
- Reset mid-load:
  - return to IDLE; the partial word in asm is dropped.
  - Already-written words keep their new contents; unwritten words keep their previous contents.

## Timing
- Reset values (cycle after Reset high): oInstruction = FILL_WORD, oInstrValid = 0, oByteReady = 0, oLoadBusy = 0, oLoadDone = 0. The FSM is in IDLE.
- Fetch latency is 1 cycle: iAddress at edge N gives oInstruction and oInstrValid = 1 after edge N+1. Fetches are back-to-back, one per cycle.
- After Reset release, the first valid output appears 1 cycle later.
- iLoadStart at edge N:
  - oLoadBusy and oByteReady rise after edge N; the first byte can be accepted at edge N+1.
  - oInstrValid falls after edge N+1; the fetch registered at edge N is still valid.
- Final byte accepted at edge M:
  - mem write at edge M; FINISH during cycle M..M+1, oLoadDone high that cycle.
  - IDLE from edge M+1; first valid fetch output after edge M+2, reading the new contents.
- Minimum load time is len × BYTES_PER_WORD cycles plus 2. Gaps in iByteValid simply stall the load.
- Reads and writes never overlap: fetch is gated in LOAD and FINISH.

## Test plan
- Reset then fetch: assert Reset 2 cycles, release, drive iAddress 0..3 → oInstruction = FILL_WORD with oInstrValid = 1, 1 cycle after each address.
- Basic load: iLoadLength = 2, bytes 0A,BC,DE,F1, 01,23,45,67 → mem[0] = 28'hABCDEF1, mem[1] = 28'h1234567; oLoadDone pulses once after the 8th byte; fetch of address 1 then returns 28'h1234567.
- Gapped bytes with a start during load: insert 3-cycle gaps between bytes and pulse iLoadStart mid-load → the second start is ignored, contents are identical to the basic load, and oInstrValid stays 0 throughout.
- Zero length: iLoadStart with iLoadLength = 0 → oLoadDone 1 cycle after start, no writes, oInstrValid back to 1 two cycles after oLoadDone.
- Overlength: ADDR_WIDTH = 2, iLoadLength = 7, feed 7×4 bytes → exactly 4 words written; oByteReady drops after byte 16; extra bytes are ignored.
- Reset mid-load: load 3 words, assert Reset after 6 bytes → mem[0] is new, mem[1] and mem[2] are old, FSM in IDLE, oLoadDone never pulses.
